alu_acc_ctrl: RTL and testbench
===============================

ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the operand/accumulator width matching the 12-bit ALU.
REQ-002 SHALL have port clk input 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n input 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port cmd_valid input 1, command present.
REQ-005 SHALL have port cmd_ready output 1, command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_load input 1: 1 = load cmd_data into acc; 0 = ALU operation.
REQ-007 SHALL have port cmd_op input 3, the ALU op_select code, passed through unmodified.
REQ-008 SHALL have port cmd_data input WIDTH, operand b or load value.
REQ-009 SHALL have ports alu_a output WIDTH, alu_b output WIDTH and alu_op output 3, driving the ALU a, b and op_select inputs.
REQ-010 SHALL have ports alu_out input WIDTH, alu_cout input 1, alu_sign input 1 and alu_overflow input 1, the combinational ALU results.
REQ-011 SHALL have port acc output WIDTH, the accumulator.
REQ-012 SHALL have ports flag_cout output 1, flag_sign output 1 and flag_ovf output 1, the flags of the last ALU write-back.
REQ-013 SHALL have port sticky_ovf output 1, overflow seen since last clear.
REQ-014 SHALL have port clr_sticky input 1, synchronous clear of sticky_ovf.
REQ-015 SHALL have port done output 1, a one-cycle pulse per completed command.
REQ-016 SHALL have port op_count output 8, count of completed ALU operations (loads excluded).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WRITE.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a handshake is cmd_valid&cmd_ready on a clock edge.
REQ-019 IDLE, handshake with cmd_load=1: acc<=cmd_data at that edge, done=1 next cycle, flags/op_count unchanged, remain IDLE.
REQ-020 IDLE, handshake with cmd_load=0: latch cmd_op and cmd_data into internal registers, go to ISSUE.
REQ-021 SHALL drive alu_a=acc, alu_b=latched operand, alu_op=latched op continuously from registers (no combinational path from cmd_* to alu_*).
REQ-022 ISSUE: one settle cycle, go to WRITE unconditionally.
REQ-023 WRITE: acc<=alu_out, flag_cout<=alu_cout, flag_sign<=alu_sign, flag_ovf<=alu_overflow, op_count<=op_count+1 (wraps 255->0), go to IDLE; done=1 in the cycle after the WRITE edge.
REQ-024 ALU-op latency SHALL be 3 edges handshake-to-acc-update; next command accepted in the cycle acc updates (throughput 1 op / 3 cycles, 1 load / cycle).
REQ-025 sticky_ovf SHALL set on the WRITE edge when alu_overflow=1; clr_sticky=1 clears it; simultaneous set and clear -> set wins.
REQ-026 cmd_valid deasserting or cmd_* changing while not IDLE SHALL have no effect.
REQ-027 done SHALL be 0 in every cycle not immediately following a completion.
REQ-028 Reset asserted mid-operation SHALL abort the command with no write-back and no done pulse.

Reset
REQ-029 While rst_n=0: state=IDLE, acc=0, latched operand=0, latched op=0, all flags=0, sticky_ovf=0, done=0, op_count=0, cmd_ready=0; cmd_ready=1 from first clk edge after release.

Verification
REQ-030 Load 0x60F, then op 6 with 0x061 -> acc=0x670, flag_ovf=0, flag_sign=0, op_count=1, done pulses twice total.
REQ-031 Load 0x69F, then op 6 with 0x769 (real ALU) -> acc=0xE08, flag_ovf=1, sticky_ovf=1; following clr_sticky -> sticky_ovf=0, flag_ovf stays 1.
REQ-032 cmd_valid held high with 4 back-to-back ALU commands -> exactly one handshake per 3 cycles, cmd_ready low in ISSUE/WRITE, op_count=4.
REQ-033 clr_sticky=1 on the same edge as an overflowing WRITE -> sticky_ovf=1.
REQ-034 rst_n pulsed low during ISSUE after load 0x123 -> acc=0, no done, op_count=0, cmd_ready=1 after release.
REQ-035 256 ALU ops (op 2, operand 0xFFF) -> op_count wraps to 0, acc unchanged from load value.

Source files
------------

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller for a combinational 12-bit ALU: accepts load/op commands,
// sequences IDLE -> ISSUE -> WRITE for ALU ops and keeps flags, sticky overflow and op count.
module alu_acc_ctrl #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_sign,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] acc,
    output logic             flag_cout,
    output logic             flag_sign,
    output logic             flag_ovf,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic             done,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;

    state_t           r_state, w_next;
    logic             r_rdy_en;
    logic [WIDTH-1:0] r_acc, r_opnd;
    logic [2:0]       r_op;
    logic             r_cout, r_sign, r_ovf, r_sticky, r_done;
    logic [7:0]       r_cnt;
    logic             w_load_hs, w_op_hs, w_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // r_rdy_en keeps cmd_ready low until the first edge after reset release.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        w_load_hs = 1'b0;
        w_op_hs   = 1'b0;
        w_write   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = r_rdy_en;
                if (cmd_valid && r_rdy_en) begin
                    if (cmd_load) begin
                        w_load_hs = 1'b1;
                    end else begin
                        w_op_hs = 1'b1;
                        w_next  = ISSUE;
                    end
                end
            end
            ISSUE: w_next = WRITE;
            WRITE: begin
                w_write = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op     <= '0;
            r_cout   <= 1'b0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_done   <= w_load_hs | w_write;
            if (w_load_hs) r_acc <= cmd_data;
            if (w_op_hs) begin
                r_opnd <= cmd_data;
                r_op   <= cmd_op;
            end
            if (w_write) begin
                r_acc  <= alu_out;
                r_cout <= alu_cout;
                r_sign <= alu_sign;
                r_ovf  <= alu_overflow;
                r_cnt  <= r_cnt + 8'd1;
            end
            // A new overflow takes priority over a same-cycle clear.
            if (w_write && alu_overflow) r_sticky <= 1'b1;
            else if (clr_sticky)         r_sticky <= 1'b0;
        end
    end

    assign alu_a      = r_acc;
    assign alu_b      = r_opnd;
    assign alu_op     = r_op;
    assign acc        = r_acc;
    assign flag_cout  = r_cout;
    assign flag_sign  = r_sign;
    assign flag_ovf   = r_ovf;
    assign sticky_ovf = r_sticky;
    assign done       = r_done;
    assign op_count   = r_cnt;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl with a behavioural 12-bit ALU and a
// transaction-level model of accumulator, flags, sticky overflow and op count.
module tb_alu_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_load, clr_sticky;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_data;
    logic        cmd_ready, alu_cout, alu_sign, alu_overflow;
    logic        flag_cout, flag_sign, flag_ovf, sticky_ovf, done;
    logic [11:0] alu_a, alu_b, alu_out, acc;
    logic [2:0]  alu_op;
    logic [7:0]  op_count;

    int nvec = 0, nerr = 0;
    int cyc = 0, hs = 0, dn = 0;

    logic [11:0] m_acc;
    logic        m_c, m_s, m_v, m_sticky;
    int          m_cnt;

    alu_acc_ctrl #(.WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_sign(alu_sign),
        .alu_overflow(alu_overflow), .acc(acc), .flag_cout(flag_cout),
        .flag_sign(flag_sign), .flag_ovf(flag_ovf), .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky), .done(done), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {cout, overflow, out[11:0]}; op 6 = add, 7 = sub, 2 = and.
    function automatic logic [13:0] alu_f(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        logic        v;
        s = 13'd0;
        v = 1'b0;
        case (op)
            3'd0: s = {1'b0, a};
            3'd1: s = {1'b0, b};
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a ^ b};
            3'd5: s = {1'b0, ~a};
            3'd6: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[11] == b[11]) && (s[11] != a[11]);
            end
            default: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[11] != b[11]) && (s[11] != a[11]);
            end
        endcase
        return {s[12], v, s[11:0]};
    endfunction

    logic [13:0] w_alu;
    assign w_alu        = alu_f(alu_op, alu_a, alu_b);
    assign alu_out      = w_alu[11:0];
    assign alu_overflow = w_alu[12];
    assign alu_cout     = w_alu[13];
    assign alu_sign     = w_alu[11];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && cmd_valid && cmd_ready) hs <= hs + 1;
        if (done) dn <= dn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, acc, m_acc);
        chk({tag, "_cout"}, flag_cout, m_c);
        chk({tag, "_sign"}, flag_sign, m_s);
        chk({tag, "_ovf"}, flag_ovf, m_v);
        chk({tag, "_sticky"}, sticky_ovf, m_sticky);
        chk({tag, "_cnt"}, op_count, m_cnt);
    endtask

    task automatic model_reset();
        m_acc = '0; m_c = 0; m_s = 0; m_v = 0; m_sticky = 0; m_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge after completion.
    task automatic send(input logic ld, input logic [2:0] op, input logic [11:0] d, input logic clr_w);
        int n;
        logic [13:0] r;
        n = 0;
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("hs_wait", n < 8, 1);
        @(negedge clk);
        if (ld) begin
            cmd_valid = 1'b0;
            m_acc = d;
            chk("ld_done", done, 1);
            chk_state("ld");
        end else begin
            chk("iss_rdy", cmd_ready, 0);
            chk("iss_done", done, 0);
            chk("iss_a", alu_a, m_acc);
            chk("iss_b", alu_b, d);
            chk("iss_op", alu_op, op);
            // garbage on the command bus must be ignored outside IDLE
            cmd_valid = 1'($urandom); cmd_load = 1'($urandom);
            cmd_op = 3'($urandom); cmd_data = 12'($urandom);
            @(negedge clk);
            chk("wr_rdy", cmd_ready, 0);
            chk("wr_done", done, 0);
            clr_sticky = clr_w;
            @(negedge clk);
            clr_sticky = 1'b0;
            cmd_valid = 1'b0;
            r = alu_f(op, m_acc, d);
            m_acc = r[11:0]; m_c = r[13]; m_v = r[12]; m_s = r[11];
            m_sticky = m_v | (m_sticky & ~clr_w);
            m_cnt = (m_cnt + 1) % 256;
            chk("op_done", done, 1);
            chk("op_rdy", cmd_ready, 1);
            chk_state("op");
        end
    endtask

    task automatic clr();
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        m_sticky = 1'b0;
        chk("clr_sticky", sticky_ovf, 0);
        chk("clr_ovf", flag_ovf, m_v);
    endtask

    initial begin
        int h0, c0, d0;
        logic [11:0] v;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0;
        cmd_data = '0; clr_sticky = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", alu_op, 0);
        chk_state("rst");
        rst_n = 1'b1;
        #1 chk("rel_rdy_pre", cmd_ready, 0);
        @(negedge clk);
        chk("rel_rdy", cmd_ready, 1);

        // load then add without overflow
        d0 = dn;
        send(1'b1, 3'd0, 12'h60F, 1'b0);
        send(1'b0, 3'd6, 12'h061, 1'b0);
        chk("add1_acc", acc, 12'h670);
        chk("add1_ovf", flag_ovf, 0);
        chk("add1_sign", flag_sign, 0);
        chk("add1_cnt", op_count, 1);
        @(negedge clk);
        chk("add1_dones", dn - d0, 2);
        chk("idle_done", done, 0);

        // signed overflow sets the sticky flag; clear leaves flag_ovf
        send(1'b1, 3'd0, 12'h69F, 1'b0);
        send(1'b0, 3'd6, 12'h769, 1'b0);
        chk("add2_acc", acc, 12'hE08);
        chk("add2_ovf", flag_ovf, 1);
        chk("add2_sticky", sticky_ovf, 1);
        clr();
        chk("add2_ovf_kept", flag_ovf, 1);

        // clear on the same edge as an overflowing write: set wins
        send(1'b1, 3'd0, 12'h7FF, 1'b0);
        send(1'b0, 3'd6, 12'h001, 1'b1);
        chk("setwin_sticky", sticky_ovf, 1);
        clr();

        // four back-to-back ops with valid held high
        h0 = hs; c0 = cyc;
        for (int i = 0; i < 4; i++) send(1'b0, 3'($urandom), 12'($urandom), 1'b0);
        chk("b2b_hs", hs - h0, 4);
        chk("b2b_cyc", cyc - c0, 12);

        // reset asserted during ISSUE aborts the op
        send(1'b1, 3'd0, 12'h123, 1'b0);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd6; cmd_data = 12'h001;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_in_issue", cmd_ready, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_rdy", cmd_ready, 0);
        chk("abort_done", done, 0);
        chk_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        d0 = dn;
        repeat (3) @(negedge clk);
        chk("abort_rdy_after", cmd_ready, 1);
        chk("abort_no_done", dn - d0, 0);
        chk_state("abort_after");

        // 256 AND-with-all-ones ops: count wraps, acc unchanged
        v = 12'($urandom);
        send(1'b1, 3'd0, v, 1'b0);
        for (int i = 0; i < 256; i++) send(1'b0, 3'd2, 12'hFFF, 1'b0);
        chk("wrap_cnt", op_count, 0);
        chk("wrap_acc", acc, v);

        // randomized mix against the model
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom), 3'($urandom), 12'($urandom), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 7) == 0) clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
